// File: rtl/disp7segs_mux.sv
// Time-multiplexed NUM_DIGITOS hex 7-segment driver, registered outputs.
// Define SUPRIME_CEROS_EN to blank leading zero digits.
module disp7segs_mux #(
  parameter int NUM_DIGITOS       = 4,
  parameter int DIV_REFRESCO      = 50000,
  parameter int ANODO_ACTIVO_BAJO = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [4*NUM_DIGITOS-1:0]   dato_i,
  input  logic                       carga_i,
  input  logic                       habilitar_i,
  output logic [6:0]                 seg_o,
  output logic [NUM_DIGITOS-1:0]     anodo_o
);

  localparam int IW = (NUM_DIGITOS > 1) ? $clog2(NUM_DIGITOS) : 1;
  localparam int PW = $clog2(DIV_REFRESCO);
  localparam logic [NUM_DIGITOS-1:0] AN_OFF =
    {NUM_DIGITOS{ANODO_ACTIVO_BAJO != 0}};
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  logic [4*NUM_DIGITOS-1:0] dato_q, dato_d;
  logic [PW-1:0]            presc_q, presc_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [6:0]               seg_q, seg_d;
  logic [NUM_DIGITOS-1:0]   anodo_q, anodo_d;

  logic [3:0]               nib;
  logic [6:0]               seg_dec;
  logic [NUM_DIGITOS-1:0]   onehot;
  logic                     blank;

  always_comb begin
    nib    = '0;
    onehot = '0;
    blank  = 1'b0;
    for (int k = 0; k < NUM_DIGITOS; k++) begin
      if (idx_q == IW'(k)) begin
        nib       = dato_q[4*k +: 4];
        onehot[k] = 1'b1;
      end
    end
`ifdef SUPRIME_CEROS_EN
    // blank unless this or some higher nibble is nonzero; digit 0 always shown
    blank = (idx_q != '0);
    for (int k = 0; k < NUM_DIGITOS; k++) begin
      if (IW'(k) >= idx_q && dato_q[4*k +: 4] != 4'h0)
        blank = 1'b0;
    end
`endif
  end

  always_comb begin
    unique case (nib)
      4'h0:    seg_dec = 7'b1000000;
      4'h1:    seg_dec = 7'b1111001;
      4'h2:    seg_dec = 7'b0100100;
      4'h3:    seg_dec = 7'b0110000;
      4'h4:    seg_dec = 7'b0011001;
      4'h5:    seg_dec = 7'b0010010;
      4'h6:    seg_dec = 7'b0000010;
      4'h7:    seg_dec = 7'b1111000;
      4'h8:    seg_dec = 7'b0000000;
      4'h9:    seg_dec = 7'b0011000;
      4'hA:    seg_dec = 7'b0001000;
      4'hB:    seg_dec = 7'b0000011;
      4'hC:    seg_dec = 7'b1000110;
      4'hD:    seg_dec = 7'b0100001;
      4'hE:    seg_dec = 7'b0000110;
      4'hF:    seg_dec = 7'b0001110;
      default: seg_dec = SEG_OFF;
    endcase
  end

  always_comb begin
    dato_d  = carga_i ? dato_i : dato_q;
    presc_d = presc_q;
    idx_d   = idx_q;
    seg_d   = SEG_OFF;
    anodo_d = AN_OFF;
    if (habilitar_i) begin
      if (!blank) begin
        seg_d   = seg_dec;
        anodo_d = onehot ^ AN_OFF;
      end
      if (presc_q == PW'(DIV_REFRESCO - 1)) begin
        presc_d = '0;
        if (idx_q == IW'(NUM_DIGITOS - 1))
          idx_d = '0;
        else
          idx_d = idx_q + IW'(1);
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dato_q  <= '0;
      presc_q <= '0;
      idx_q   <= '0;
      seg_q   <= SEG_OFF;
      anodo_q <= AN_OFF;
    end else begin
      dato_q  <= dato_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      anodo_q <= anodo_d;
    end
  end

  assign seg_o   = seg_q;
  assign anodo_o = anodo_q;

endmodule

// File: tb/tb_disp7segs_mux.sv
// Scoreboard bench for disp7segs_mux, 4 digits, 4-cycle refresh.
// Follows SUPRIME_CEROS_EN when defined for the build.
module tb_disp7segs_mux;

  localparam int N   = 4;
  localparam int DIV = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [15:0] dato_i = '0;
  logic        carga_i = 1'b0;
  logic        habilitar_i = 1'b0;
  logic [6:0]  seg_o;
  logic [3:0]  anodo_o;

  disp7segs_mux #(
    .NUM_DIGITOS(N),
    .DIV_REFRESCO(DIV),
    .ANODO_ACTIVO_BAJO(1)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .dato_i(dato_i),
    .carga_i(carga_i),
    .habilitar_i(habilitar_i),
    .seg_o(seg_o),
    .anodo_o(anodo_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_fail = 0;

  logic [6:0] sq[$];
  logic [3:0] aq[$];
  logic [15:0] m_dato = '0;
  int m_presc = 0;
  int m_idx = 0;
  logic [6:0] es;
  logic [3:0] ea;

  function automatic logic [6:0] dec(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0011000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  // drive one clock, push the model's expected outputs for that edge
  task automatic cyc(input logic r, input logic h, input logic c,
                     input logic [15:0] d);
    logic [6:0] s;
    logic [3:0] a;
    bit bl;
    rst_i = r; habilitar_i = h; carga_i = c; dato_i = d;
    s = 7'h7F; a = 4'hF;
    if (r) begin
      m_dato = '0; m_presc = 0; m_idx = 0;
    end else begin
      bl = 1'b0;
`ifdef SUPRIME_CEROS_EN
      bl = (m_idx > 0) && ((m_dato >> (4 * m_idx)) == 16'h0);
`endif
      if (h && !bl) begin
        s = dec(m_dato[4*m_idx +: 4]);
        a = ~(4'b0001 << m_idx);
      end
      if (h) begin
        if (m_presc == DIV - 1) begin
          m_presc = 0;
          m_idx = (m_idx + 1) % N;
        end else m_presc++;
      end
      if (c) m_dato = d;
    end
    sq.push_back(s);
    aq.push_back(a);
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 4; i++) begin
      cyc(i < 3, 1'b0, 1'b0, 16'h0);
      es = sq.pop_front(); ea = aq.pop_front();
      n_chk++;
      if (seg_o !== 7'h7F || anodo_o !== 4'hF || seg_o !== es
          || anodo_o !== ea) begin
        n_fail++;
        $display("FAIL reset[%0d] seg=%b an=%b want seg=%b an=%b",
                 i, seg_o, anodo_o, es, ea);
      end
    end
  endtask

  task automatic test_scan;
    logic [6:0] lut [4];
    int dg;
    lut[0] = 7'b0011001; lut[1] = 7'b0110000;
    lut[2] = 7'b0100100; lut[3] = 7'b1111001;
    cyc(1'b0, 1'b0, 1'b1, 16'h1234);
    es = sq.pop_front(); ea = aq.pop_front();
    for (int i = 0; i < 32; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 16'h0);
      es = sq.pop_front(); ea = aq.pop_front();
      dg = (i / 4) % 4;
      n_chk++;
      if (seg_o !== es || anodo_o !== ea || seg_o !== lut[dg]
          || anodo_o !== ~(4'b0001 << dg)) begin
        n_fail++;
        $display("FAIL scan[%0d] seg=%b an=%b want seg=%b an=%b",
                 i, seg_o, anodo_o, es, ea);
      end
    end
  endtask

  task automatic test_decode;
    for (int v = 0; v < 16; v++) begin
      cyc(1'b1, 1'b0, 1'b0, 16'h0);
      cyc(1'b0, 1'b0, 1'b1, 16'(v));
      cyc(1'b0, 1'b1, 1'b0, 16'h0);
      repeat (2) begin
        es = sq.pop_front(); ea = aq.pop_front();
      end
      es = sq.pop_front(); ea = aq.pop_front();
      n_chk++;
      if (seg_o !== es || anodo_o !== 4'b1110
          || (v == 7 && seg_o !== 7'b1111000)) begin
        n_fail++;
        $display("FAIL decode[%0h] seg=%b an=%b want seg=%b an=1110",
                 v, seg_o, anodo_o, es);
      end
    end
  endtask

  task automatic test_collision;
    cyc(1'b1, 1'b0, 1'b0, 16'h0);
    cyc(1'b0, 1'b0, 1'b1, 16'h1234);
    repeat (2) begin
      es = sq.pop_front(); ea = aq.pop_front();
    end
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 1'b1, i == 3, (i == 3) ? 16'hFFFF : 16'h0);
      es = sq.pop_front(); ea = aq.pop_front();
      n_chk++;
      if (seg_o !== es || anodo_o !== ea
          || (i == 3 && (seg_o !== 7'b0011001 || anodo_o !== 4'b1110))
          || (i == 4 && (seg_o !== 7'b0001110 || anodo_o !== 4'b1101)))
      begin
        n_fail++;
        $display("FAIL collision[%0d] seg=%b an=%b want seg=%b an=%b",
                 i, seg_o, anodo_o, es, ea);
      end
    end
  endtask

  task automatic test_disable_reset;
    logic r, h;
    cyc(1'b1, 1'b0, 1'b0, 16'h0);
    cyc(1'b0, 1'b0, 1'b1, 16'h1234);
    repeat (2) begin
      es = sq.pop_front(); ea = aq.pop_front();
    end
    // 9 enabled, 10 disabled, 6 enabled, reset, 1 enabled
    for (int i = 0; i < 27; i++) begin
      h = !(i >= 9 && i < 19);
      r = (i == 25);
      cyc(r, h, 1'b0, 16'h0);
      es = sq.pop_front(); ea = aq.pop_front();
      n_chk++;
      if (seg_o !== es || anodo_o !== ea
          || (!h && (seg_o !== 7'h7F || anodo_o !== 4'hF))
          || (i == 21 && anodo_o !== 4'b1011)
          || (i == 22 && (anodo_o !== 4'b0111 || seg_o !== 7'b1111001))
          || (r && anodo_o !== 4'hF)
          || (i == 26 && anodo_o !== 4'b1110)) begin
        n_fail++;
        $display("FAIL dis_rst[%0d] seg=%b an=%b want seg=%b an=%b",
                 i, seg_o, anodo_o, es, ea);
      end
    end
  endtask

  task automatic test_blank;
    logic [15:0] vals [2];
    int lit, want;
    vals[0] = 16'h0050; vals[1] = 16'h0000;
    for (int t = 0; t < 2; t++) begin
      cyc(1'b1, 1'b0, 1'b0, 16'h0);
      cyc(1'b0, 1'b0, 1'b1, vals[t]);
      repeat (2) begin
        es = sq.pop_front(); ea = aq.pop_front();
      end
      lit = 0;
      for (int i = 0; i < 16; i++) begin
        cyc(1'b0, 1'b1, 1'b0, 16'h0);
        es = sq.pop_front(); ea = aq.pop_front();
        if (anodo_o !== 4'hF) lit++;
        n_chk++;
        if (seg_o !== es || anodo_o !== ea) begin
          n_fail++;
          $display("FAIL blank%0d[%0d] seg=%b an=%b want seg=%b an=%b",
                   t, i, seg_o, anodo_o, es, ea);
        end
      end
      want = 16;
`ifdef SUPRIME_CEROS_EN
      want = (t == 0) ? 8 : 4;
`endif
      n_chk++;
      if (lit != want) begin
        n_fail++;
        $display("FAIL blank_count%0d lit=%0d want=%0d", t, lit, want);
      end
    end
  endtask

  initial begin
    test_reset;
    test_scan;
    test_decode;
    test_collision;
    test_disable_reset;
    test_blank;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
